// File: rtl/rca_pipe.sv
// rca_pipe: pipelined segmented ripple-carry adder/subtractor with valid/ready flow control
// Ports: clk, rst (async, active-high); a, b, cin, sub, in_valid -> in_ready;
//        sum, cout, ovf, out_valid -> out_ready.
module rca_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int SW = WIDTH / SEG;
  if (WIDTH % SEG != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_params
    $error("rca_pipe: WIDTH must be 4..64 and a multiple of SEG");
  end
  function automatic logic [SW:0] rca(input logic [SW-1:0] x, input logic [SW-1:0] y, input logic c);
    logic [SW-1:0] s;
    logic          cc;
    cc = c;
    for (int i = 0; i < SW; i++) begin
      s[i] = x[i] ^ y[i] ^ cc;
      cc   = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
    end
    return {cc, s};
  endfunction
  // Operand skew registers shift right one slice per stage so the slice to add
  // is always at the bottom; the sum register shifts right with each new slice
  // entering at the top, so it lands fully aligned after the last stage.
  logic [WIDTH-1:0] r_a [SEG];
  logic [WIDTH-1:0] r_b [SEG];
  logic [WIDTH-1:0] r_s [SEG];
  logic             r_c [SEG];
  logic             r_am[SEG];
  logic             r_bm[SEG];
  logic             r_v [SEG];
  logic [WIDTH-1:0] w_a [SEG];
  logic [WIDTH-1:0] w_b [SEG];
  logic [WIDTH-1:0] w_s [SEG];
  logic             w_c [SEG];
  logic             w_am[SEG];
  logic             w_bm[SEG];
  logic             w_v [SEG];
  logic [SW:0]      w_r [SEG];
  logic             w_adv;
  always_comb begin
    w_a[0]  = a;
    w_b[0]  = sub ? ~b : b;
    w_c[0]  = sub | cin;
    w_s[0]  = '0;
    w_am[0] = a[WIDTH-1];
    w_bm[0] = b[WIDTH-1] ^ sub;
    w_v[0]  = in_valid;
    for (int k = 1; k < SEG; k++) begin
      w_a[k]  = r_a[k-1];
      w_b[k]  = r_b[k-1];
      w_c[k]  = r_c[k-1];
      w_s[k]  = r_s[k-1];
      w_am[k] = r_am[k-1];
      w_bm[k] = r_bm[k-1];
      w_v[k]  = r_v[k-1];
    end
    for (int k = 0; k < SEG; k++) w_r[k] = rca(w_a[k][SW-1:0], w_b[k][SW-1:0], w_c[k]);
  end
  assign w_adv = !r_v[SEG-1] || out_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SEG; k++) begin
        r_a[k]  <= '0;
        r_b[k]  <= '0;
        r_s[k]  <= '0;
        r_c[k]  <= 1'b0;
        r_am[k] <= 1'b0;
        r_bm[k] <= 1'b0;
        r_v[k]  <= 1'b0;
      end
    end else if (w_adv) begin
      for (int k = 0; k < SEG; k++) begin
        r_a[k]  <= w_a[k] >> SW;
        r_b[k]  <= w_b[k] >> SW;
        r_s[k]  <= (w_s[k] >> SW) | (WIDTH'(w_r[k][SW-1:0]) << (WIDTH - SW));
        r_c[k]  <= w_r[k][SW];
        r_am[k] <= w_am[k];
        r_bm[k] <= w_bm[k];
        r_v[k]  <= w_v[k];
      end
    end
  end
  assign in_ready  = w_adv;
  assign out_valid = r_v[SEG-1];
  assign sum       = r_s[SEG-1];
  assign cout      = r_c[SEG-1];
  assign ovf       = (r_am[SEG-1] == r_bm[SEG-1]) && (r_s[SEG-1][WIDTH-1] != r_am[SEG-1]);
endmodule

// File: tb/tb_rca_pipe.sv
// tb_rca_pipe: directed and scoreboarded checks of rca_pipe in SEG=4, SEG=1 and SEG=16 builds
module tb_rca_pipe;
  localparam int W = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic cin = 1'b0, sub = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, cout, ovf, out_valid;
  logic [W-1:0] sum;
  logic in_ready1, cout1, ovf1, out_valid1;
  logic [W-1:0] sum1;
  logic in_ready16, cout16, ovf16, out_valid16;
  logic [W-1:0] sum16;
  int n_vec = 0, n_err = 0;
  logic [17:0] q4[$], q1[$], q16[$];

  rca_pipe #(.WIDTH(W), .SEG(4)) u_dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .sub(sub), .in_valid(in_valid),
    .in_ready(in_ready), .sum(sum), .cout(cout), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready));
  rca_pipe #(.WIDTH(W), .SEG(1)) u_s1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .sub(sub), .in_valid(in_valid),
    .in_ready(in_ready1), .sum(sum1), .cout(cout1), .ovf(ovf1), .out_valid(out_valid1), .out_ready(out_ready));
  rca_pipe #(.WIDTH(W), .SEG(16)) u_s16 (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .sub(sub), .in_valid(in_valid),
    .in_ready(in_ready16), .sum(sum16), .cout(cout16), .ovf(ovf16), .out_valid(out_valid16), .out_ready(out_ready));

  always #5 clk = ~clk;

  function automatic logic [17:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
    logic [W-1:0] yy;
    logic [W:0]   f;
    logic         ov;
    yy = s ? ~y : y;
    f  = {1'b0, x} + {1'b0, yy} + {16'h0, (s ? 1'b1 : c)};
    ov = (x[W-1] == yy[W-1]) && (f[W-1] != x[W-1]);
    return {f[W], ov, f[W-1:0]};
  endfunction

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    n_vec++;
    if ({out_valid, cout, ovf, sum} !== 19'h0) begin
      n_err++; $display("FAIL reset_outputs got %b want 0", {out_valid, cout, ovf, sum});
    end
    @(negedge clk); rst = 1'b0; #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add_wrap;
    @(negedge clk); a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); in_valid = 1'b0;
      n_vec++;
      if (i == 4) begin
        if ({out_valid, cout, ovf, sum} !== {1'b1, 1'b1, 1'b0, 16'h0000}) begin
          n_err++; $display("FAIL add_wrap got v=%b c=%b o=%b s=%h want v=1 c=1 o=0 s=0000", out_valid, cout, ovf, sum);
        end
      end else if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL add_wrap_latency cycle %0d got out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_ovf_sub;
    @(negedge clk); a = 16'h7FFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); a = 16'h0005; b = 16'h0007; cin = 1'b1; sub = 1'b1;
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk); in_valid = 1'b0;
      n_vec++;
      if (i == 4) begin
        if ({out_valid, cout, ovf, sum} !== {1'b1, 1'b0, 1'b1, 16'h8000}) begin
          n_err++; $display("FAIL ovf_add got v=%b c=%b o=%b s=%h want v=1 c=0 o=1 s=8000", out_valid, cout, ovf, sum);
        end
      end else if (i == 5) begin
        if ({out_valid, cout, ovf, sum} !== {1'b1, 1'b0, 1'b0, 16'hFFFE}) begin
          n_err++; $display("FAIL sub_neg got v=%b c=%b o=%b s=%h want v=1 c=0 o=0 s=fffe", out_valid, cout, ovf, sum);
        end
      end else if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL ovf_sub_latency cycle %0d got out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    int tx, rx;
    tx = 0; rx = 0;
    for (int t = 0; t < 60 && rx < 10; t++) begin
      @(negedge clk);
      out_ready = !(t >= 6 && t <= 8);
      in_valid = tx < 10; a = W'(tx); b = W'(32'h1000 * tx); cin = 1'b0; sub = 1'b0;
      #1;
      n_vec++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        n_err++; $display("FAIL b2b_in_ready t=%0d got %b want %b", t, in_ready, !(out_valid && !out_ready));
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if ({cout, ovf, sum} !== {2'b00, W'(rx + 32'h1000 * rx)}) begin
          n_err++; $display("FAIL b2b_result %0d got c=%b o=%b s=%h want c=0 o=0 s=%h", rx, cout, ovf, sum, W'(rx + 32'h1000 * rx));
        end
        rx++;
      end
      if (in_valid && in_ready) tx++;
    end
    n_vec++;
    if (rx != 10) begin n_err++; $display("FAIL b2b_count got %0d results want 10", rx); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_extra got out_valid=%b want 0", out_valid); end
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk); a = W'(32'h1111 * (t + 1)); b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    end
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if ({out_valid, cout, ovf, sum, out_valid1, sum1, out_valid16} !== 37'h0) begin
      n_err++; $display("FAIL rst_mid_outputs got v=%b c=%b o=%b s=%h v1=%b s1=%h v16=%b want all 0",
        out_valid, cout, ovf, sum, out_valid1, sum1, out_valid16);
    end
    @(negedge clk); rst = 1'b0; in_valid = 1'b0; #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); n_vec++;
      if ({out_valid, out_valid1, out_valid16} !== 3'b000) begin
        n_err++; $display("FAIL rst_mid_ghost cycle %0d got v4=%b v1=%b v16=%b want 0", i, out_valid, out_valid1, out_valid16);
      end
    end
  endtask

  task automatic test_seg_variants;
    logic [W-1:0] va[2], vb[2];
    logic vc[2], vs[2];
    logic [17:0] ve[2];
    va[0] = 16'h1234; vb[0] = 16'h0FF0; vc[0] = 1'b0; vs[0] = 1'b1; ve[0] = {1'b1, 1'b0, 16'h0244};
    va[1] = 16'h8000; vb[1] = 16'h8000; vc[1] = 1'b1; vs[1] = 1'b0; ve[1] = {1'b1, 1'b1, 16'h0001};
    for (int v = 0; v < 2; v++) begin
      @(negedge clk); a = va[v]; b = vb[v]; cin = vc[v]; sub = vs[v]; in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 1; i <= 17; i++) begin
        @(negedge clk); in_valid = 1'b0;
        n_vec++;
        if ({out_valid1, out_valid, out_valid16} !== {i == 1, i == 4, i == 16}) begin
          n_err++; $display("FAIL seg_latency vec %0d cycle %0d got v1=%b v4=%b v16=%b", v, i, out_valid1, out_valid, out_valid16);
        end
        if (i == 1) begin
          n_vec++;
          if ({cout1, ovf1, sum1} !== ve[v]) begin n_err++; $display("FAIL seg1_result vec %0d got %h want %h", v, {cout1, ovf1, sum1}, ve[v]); end
        end
        if (i == 16) begin
          n_vec++;
          if ({cout16, ovf16, sum16} !== ve[v]) begin n_err++; $display("FAIL seg16_result vec %0d got %h want %h", v, {cout16, ovf16, sum16}, ve[v]); end
        end
      end
    end
  endtask

  task automatic test_random;
    logic [17:0] exp_v;
    for (int t = 0; t < 1040; t++) begin
      @(negedge clk);
      in_valid  = t < 1000 ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = t < 1000 ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      #1;
      exp_v = ref_model(a, b, cin, sub);
      if (out_valid && out_ready) begin
        n_vec++;
        if (q4.size() == 0) begin n_err++; $display("FAIL rand4_spurious got %h want none", {cout, ovf, sum}); end
        else if ({cout, ovf, sum} !== q4[0]) begin n_err++; $display("FAIL rand4 got %h want %h", {cout, ovf, sum}, q4[0]); end
        if (q4.size() != 0) void'(q4.pop_front());
      end
      if (out_valid1 && out_ready) begin
        n_vec++;
        if (q1.size() == 0) begin n_err++; $display("FAIL rand1_spurious got %h want none", {cout1, ovf1, sum1}); end
        else if ({cout1, ovf1, sum1} !== q1[0]) begin n_err++; $display("FAIL rand1 got %h want %h", {cout1, ovf1, sum1}, q1[0]); end
        if (q1.size() != 0) void'(q1.pop_front());
      end
      if (out_valid16 && out_ready) begin
        n_vec++;
        if (q16.size() == 0) begin n_err++; $display("FAIL rand16_spurious got %h want none", {cout16, ovf16, sum16}); end
        else if ({cout16, ovf16, sum16} !== q16[0]) begin n_err++; $display("FAIL rand16 got %h want %h", {cout16, ovf16, sum16}, q16[0]); end
        if (q16.size() != 0) void'(q16.pop_front());
      end
      if (in_valid && in_ready) q4.push_back(exp_v);
      if (in_valid && in_ready1) q1.push_back(exp_v);
      if (in_valid && in_ready16) q16.push_back(exp_v);
    end
    n_vec++;
    if (q4.size() + q1.size() + q16.size() != 0) begin
      n_err++; $display("FAIL rand_drain got %0d/%0d/%0d pending want 0", q4.size(), q1.size(), q16.size());
    end
  endtask

  initial begin
    test_reset;
    test_add_wrap;
    test_ovf_sub;
    test_back_to_back;
    test_reset_mid;
    test_seg_variants;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rca_pipe.md
RCA_PIPE -- requirements
Module: rca_pipe

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16, as the operand and sum width in bits (legal values 4..64).
REQ-002 The block SHALL take parameter SEG, default 4, as the number of carry segments and pipeline stages; WIDTH SHALL be a multiple of SEG, checked at elaboration.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, used in add mode only.
REQ-008 The block SHALL have port sub, input, 1 bit: 0 = add, 1 = subtract.
REQ-009 The block SHALL have port in_valid, input, 1 bit: operands are valid this cycle.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-011 The block SHALL have port sum, output, WIDTH bits: result.
REQ-012 The block SHALL have port cout, output, 1 bit: carry out of the MSB.
REQ-013 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-014 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-015 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-016 Operation: sub=0 -> sum/cout = a + b + cin; sub=1 -> a + ~b + 1 (cin ignored); the result is modulo 2^WIDTH, with cout being bit WIDTH of the full sum.
REQ-017 ovf SHALL equal (A_msb == B'_msb) && (sum_msb != A_msb), where B' is b or ~b as selected by sub.
REQ-018 Datapath SHALL be split into SEG segments of WIDTH/SEG bits, each a ripple-carry chain of full adders.
REQ-019 Stage k (1..SEG) SHALL compute segment k-1 using the carry registered by stage k-1; stage 1 SHALL use the effective carry-in.
REQ-020 Not-yet-added upper operand slices and already-computed lower sum slices SHALL be carried forward in skew registers alongside each stage.
REQ-021 Each stage SHALL hold a valid bit v[k]; out_valid = v[SEG].
REQ-022 Advance condition: adv = !v[SEG] || out_ready; in_ready = adv (combinational).
REQ-023 When adv=1, all stages SHALL shift one place: v[1] <= in_valid, v[k] <= v[k-1]; when adv=0, all stage registers, including data, SHALL hold.
REQ-024 Bubbles SHALL NOT be collapsed; invalid stages shift like valid ones.
REQ-025 Latency SHALL be exactly SEG cycles from an accepted input (in_valid && in_ready) to out_valid, absent stalls; throughput SHALL be 1 result per cycle while out_ready=1.
REQ-026 A transfer SHALL complete on a cycle with out_valid && out_ready; while out_valid=1 and out_ready=0, sum/cout/ovf/out_valid SHALL stay stable.
REQ-027 Operands presented with in_valid=1 and in_ready=0 SHALL NOT be captured; the source holds them.
REQ-028 Simultaneous output transfer and input acceptance in the same cycle SHALL be supported with no loss or duplication.
REQ-029 With SEG=1, the block SHALL behave as a single-stage registered WIDTH-bit adder with latency 1.
REQ-030 Results SHALL emerge in strict input order.

Reset
REQ-031 While rst=1, all v[k], out_valid, sum, cout, ovf and all internal registers SHALL be 0, asynchronously.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight results; no out_valid SHALL appear for pre-reset inputs.
REQ-033 After rst deasserts, in_ready SHALL be 1 on the first cycle (pipeline empty).

Verification (WIDTH=16, SEG=4 unless stated)
REQ-034 a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 -> 4 cycles later: sum=0x0000, cout=1, ovf=0, out_valid=1 for 1 cycle.
REQ-035 a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1; then a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0.
REQ-036 10 back-to-back inputs (a=i, b=0x1000*i), out_ready=0 during cycles 6-8 -> in_ready=0 exactly while out_valid && !out_ready; all 10 results correct, in order, none lost or duplicated.
REQ-037 Inputs accepted on 3 consecutive cycles, rst pulsed on cycle 2 -> all outputs 0 immediately; no out_valid afterwards until new inputs; in_ready=1 the first cycle after release.
REQ-038 SEG=1 and SEG=16 builds; 1000 random operand/sub/cin vectors with random out_ready -> every result matches a reference model; latency = SEG cycles when out_ready=1.
